// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stall, timed mult/div
// freeze of EX, taken-branch flush of IF/ID, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MD_CYCLES       = 32,
  parameter int CNT_WIDTH       = 6,
  parameter int STALL_CNT_WIDTH = 32,
  parameter int REG_ADDR_WIDTH  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ReadMem_EX,
  input  logic [REG_ADDR_WIDTH-1:0]  rt_EX,
  input  logic [REG_ADDR_WIDTH-1:0]  raddr_1_ID,
  input  logic [REG_ADDR_WIDTH-1:0]  raddr_2_ID,
  input  logic                       re_1_ID,
  input  logic                       re_2_ID,
  input  logic                       md_start_EX,
  input  logic                       branch_taken_ID,
  output logic                       hold_PC,
  output logic                       hold_IF_ID,
  output logic                       hold_ID_EX,
  output logic                       bubble_ID_EX,
  output logic                       bubble_EX_MEM,
  output logic                       flush_IF_ID,
  output logic                       md_busy,
  output logic                       md_done,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(MD_CYCLES - 2);

  state_t                     r_state;
  logic [CNT_WIDTH-1:0]       r_cnt;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

  logic w_load_use;
  logic w_md_hold;
  logic w_hold;
  logic w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  assign w_load_use = ReadMem_EX && (rt_EX != '0) &&
                      ((re_1_ID && (raddr_1_ID == rt_EX)) ||
                       (re_2_ID && (raddr_2_ID == rt_EX)));

  // The instruction is held in EX for MD_CYCLES-1 cycles; the final cycle releases
  assign w_md_hold = ((r_state == IDLE) && md_start_EX) ||
                     ((r_state == BUSY) && !w_cnt_zero);

  assign w_hold = !rst && (w_md_hold || w_load_use);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (md_start_EX) begin
            r_state <= BUSY;
            r_cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_hold && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
      end
    end
  end

  // Every control output is gated by rst so the pipeline sees no stall/flush in reset
  assign hold_PC       = w_hold;
  assign hold_IF_ID    = w_hold;
  assign hold_ID_EX    = !rst && w_md_hold;
  assign bubble_ID_EX  = !rst && w_load_use && !w_md_hold;
  assign bubble_EX_MEM = !rst && w_md_hold;
  assign flush_IF_ID   = !rst && branch_taken_ID && !w_md_hold && !w_load_use;
  assign md_busy       = !rst && (r_state == BUSY);
  assign md_done       = !rst && (r_state == BUSY) && w_cnt_zero;
  assign stall_cnt     = r_stall_cnt;

endmodule
